// File: rtl/conv_pipe_pkg.sv
// conv_pipe_pkg: shared constants and width helpers for conv_pipe_multi.
// Default kernels use a 3-bit layout, coefficient c[i] at [i*3 +: 3].
package conv_pipe_pkg;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // c8..c0 from left to right, row-major, c0 top-left
  localparam logic [26:0] KERN_SOBEL_X =
    27'b001_000_111_010_000_110_001_000_111;
  localparam logic [26:0] KERN_SOBEL_Y =
    27'b001_010_001_000_000_000_111_110_111;
  localparam logic [26:0] KERN_DIAG_R =
    27'b000_111_110_001_000_111_010_001_000;
  localparam logic [26:0] KERN_DIAG_L =
    27'b010_001_000_001_000_111_000_111_110;

  function automatic int gw_of(int pix_w, int coef_w);
    return pix_w + coef_w + 5;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(int gw, int n);
    return gw + ((n > 1) ? $clog2(n) : 0);
  endfunction

  function automatic logic [26:0] def_kern(int k);
    case (k)
      0: return KERN_SOBEL_X;
      1: return KERN_SOBEL_Y;
      2: return KERN_DIAG_R;
      3: return KERN_DIAG_L;
      default: return 27'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_pipe_multi_dot9.sv
// conv_pipe_dot9: registered signed 9-tap dot product.
// Pixels are unsigned, coefficients signed; result held when en=0.
module conv_pipe_dot9
  import conv_pipe_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 3,
  parameter int GW     = gw_of(PIX_W, COEF_W)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [9*PIX_W-1:0]      pix,
  input  logic [9*COEF_W-1:0]     coef,
  output logic signed [GW-1:0]    dot
);

  logic signed [GW-1:0] acc;
  logic signed [GW-1:0] px;
  logic signed [GW-1:0] cf;

  // multiply-accumulate of all nine taps
  always_comb begin
    acc = '0;
    px  = '0;
    cf  = '0;
    for (int i = 0; i < 9; i++) begin
      px = {{(GW-PIX_W){1'b0}},
            pix[i*PIX_W +: PIX_W]};
      cf = {{(GW-COEF_W){coef[i*COEF_W+COEF_W-1]}},
            coef[i*COEF_W +: COEF_W]};
      acc = acc + px * cf;
    end
  end

  // product register, frozen while the pipe is stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dot <= '0;
    else if (en)
      dot <= acc;
  end

endmodule

// File: rtl/conv_pipe_multi.sv
// conv_pipe_multi: 3-stage multi-kernel 3x3 gradient engine.
// Optional threshold output enabled by define CONV_PIPE_THRESH_EN.
module conv_pipe_multi
  import conv_pipe_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 3,
  parameter int NUM_K  = 4,
  parameter int MAG_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [9*PIX_W-1:0]        in_window,
  input  logic                      mode,
  input  logic                      kern_wr_en,
  input  logic [idx_w(NUM_K)-1:0]   kern_wr_idx,
  input  logic [9*COEF_W-1:0]       kern_wr_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAG_W-1:0]          out_mag,
`ifdef CONV_PIPE_THRESH_EN
  input  logic [MAG_W-1:0]          thresh,
  output logic                      out_edge,
`endif
  output logic                      busy
);

  localparam int GW = gw_of(PIX_W, COEF_W);
  localparam int IW = idx_w(NUM_K);
  localparam int SW = sum_w(GW, NUM_K);
  localparam int XW = SW + MAG_W;
  localparam logic [XW-1:0] SAT_MAX =
    {{SW{1'b0}}, {MAG_W{1'b1}}};

  logic                  stall;
  logic                  v1;
  logic                  v2;
  logic                  m1;
  logic [GW-1:0]         mag_k;
  logic [SW-1:0]         comb;
  logic [SW-1:0]         c2;
  logic [XW-1:0]         wide;
  logic [MAG_W-1:0]      sat;
  logic [9*COEF_W-1:0]   bank [NUM_K];
  logic signed [GW-1:0]  g [NUM_K];

  function automatic logic [9*COEF_W-1:0] widen(
    input logic [26:0] d
  );
    logic [9*COEF_W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      r[i*COEF_W +: COEF_W] =
        COEF_W'($signed(d[i*3 +: 3]));
    return r;
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign busy     = v1 || v2 || out_valid;

  // kernel bank: defaults on reset, runtime overwrite
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_K; k++)
        bank[k] <= widen(def_kern(k));
    end else if (kern_wr_en &&
                 ({1'b0, kern_wr_idx} <
                  (IW+1)'(NUM_K))) begin
      bank[kern_wr_idx] <= kern_wr_data;
    end
  end

  for (genvar k = 0; k < NUM_K; k++) begin : g_dot
    conv_pipe_dot9 #(
      .PIX_W  (PIX_W),
      .COEF_W (COEF_W),
      .GW     (GW)
    ) u_dot (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (in_ready),
      .pix     (in_window),
      .coef    (bank[k]),
      .dot     (g[k])
    );
  end

  // S1 control: window valid and its mode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      m1 <= MODE_SUM;
    end else if (!stall) begin
      v1 <= in_valid;
      m1 <= mode;
    end
  end

  // S2 combine: L1 sum or max of |g_k|
  always_comb begin
    comb  = '0;
    mag_k = '0;
    for (int k = 0; k < NUM_K; k++) begin
      mag_k = g[k][GW-1] ? GW'(-g[k]) : GW'(g[k]);
      if (m1 == MODE_MAX) begin
        if (SW'(mag_k) > comb)
          comb = SW'(mag_k);
      end else begin
        comb = comb + SW'(mag_k);
      end
    end
  end

  // S2 register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2 <= 1'b0;
      c2 <= '0;
    end else if (!stall) begin
      v2 <= v1;
      c2 <= comb;
    end
  end

  assign wide = XW'(c2);
  assign sat  = (wide > SAT_MAX) ? '1 :
                wide[MAG_W-1:0];

  // S3 output register, held under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
    end else if (!stall) begin
      out_valid <= v2;
      if (v2)
        out_mag <= sat;
    end
  end

`ifdef CONV_PIPE_THRESH_EN
  // edge flag travels with the magnitude
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_edge <= 1'b0;
    else if (!stall && v2)
      out_edge <= (sat >= thresh);
  end
`endif

endmodule
